// File: rtl/img_pkg.sv
// Shared image-dimension types for the column and row counters.
package img_pkg;
  localparam int IMG_DIM_W = 13;
  typedef logic [IMG_DIM_W-1:0] img_dim_t;
endpackage

// File: rtl/i_col_counter.sv
// Column index counter: 0..rollover_val-2, then wraps to 0 with a registered rollover_flag.
// Optional last_col output (combinational, value == terminal) enabled by I_COL_COUNTER_LAST_EN.
module i_col_counter
  import img_pkg::*;
#(
  parameter int WIDTH = IMG_DIM_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
`ifdef I_COL_COUNTER_LAST_EN
  output logic             last_col,
`endif
  output logic [WIDTH-1:0] value,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] value_nxt;
  logic             flag_nxt;

  // Terminal saturates at 0 for widths below 2; >= also catches a width lowered mid-row.
  always_comb begin
    term      = (rollover_val < WIDTH'(2)) ? '0 : rollover_val - WIDTH'(2);
    value_nxt = value;
    flag_nxt  = rollover_flag;
    if (clear) begin
      value_nxt = '0;
      flag_nxt  = 1'b0;
    end else if (count_enable) begin
      if (value >= term) begin
        value_nxt = '0;
        flag_nxt  = 1'b1;
      end else begin
        value_nxt = value + WIDTH'(1);
        flag_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value         <= '0;
      rollover_flag <= 1'b0;
    end else begin
      value         <= value_nxt;
      rollover_flag <= flag_nxt;
    end
  end

`ifdef I_COL_COUNTER_LAST_EN
  assign last_col = (value == term);
`endif

endmodule

// File: tb/tb_i_col_counter.sv
// Scoreboard bench for i_col_counter: driver pushes expected state per cycle, monitor pops and compares.
module tb_i_col_counter;
  localparam int W = 13;

  logic         clk;
  logic         n_rst;
  logic         clear;
  logic         count_enable;
  logic [W-1:0] rollover_val;
  logic [W-1:0] value;
  logic         rollover_flag;
`ifdef I_COL_COUNTER_LAST_EN
  logic         last_col;
`endif

  i_col_counter #(.WIDTH(W)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (count_enable),
    .rollover_val  (rollover_val),
`ifdef I_COL_COUNTER_LAST_EN
    .last_col      (last_col),
`endif
    .value         (value),
    .rollover_flag (rollover_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit flag;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: column position and wrap flag as plain integers.
  int m_val  = 0;
  bit m_flag = 0;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock of stimulus; the expected post-edge state is queued for the monitor.
  task automatic step(input bit clr, input bit en, input int rv);
    int   t;
    exp_t e;
    @(negedge clk);
    clear        = clr;
    count_enable = en;
    rollover_val = W'(rv);
    t = (rv < 2) ? 0 : rv - 2;
    if (clr) begin
      m_val  = 0;
      m_flag = 0;
    end else if (en) begin
      if (m_val >= t) begin
        m_val  = 0;
        m_flag = 1;
      end else begin
        m_val  = m_val + 1;
        m_flag = 0;
      end
    end
    e.val  = m_val;
    e.flag = m_flag;
    e.last = (m_val == t);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic enables_with_gaps(input int n, input int gap, input int rv);
    for (int i = 0; i < n; i++) begin
      step(0, 1, rv);
      for (int k = 0; k < gap; k++) step(0, 0, rv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("value", int'(value), e.val);
      check("rollover_flag", int'(rollover_flag), int'(e.flag));
`ifdef I_COL_COUNTER_LAST_EN
      check("last_col", int'(last_col), int'(e.last));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst        = 1'b0;
    clear        = 1'b0;
    count_enable = 1'b0;
    rollover_val = W'(10);
    #12;
    check("reset_value", int'(value), 0);
    check("reset_flag", int'(rollover_flag), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Asynchronous reset mid-count at value 5.
    step(1, 0, 10);
    enables_with_gaps(5, 0, 10);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_value", int'(value), 0);
    check("async_rst_flag", int'(rollover_flag), 0);
    m_val  = 0;
    m_flag = 0;
    @(negedge clk);
    n_rst = 1'b1;

    // Width 10: 1..8, wrap with flag, then 1 with flag cleared.
    step(1, 0, 10);
    enables_with_gaps(10, 3, 10);

    // Width 100: reaches 98, wraps, then 1; idle cycles hold.
    step(1, 0, 100);
    enables_with_gaps(100, 3, 100);

    // Full-scale width: counts to 8189 then wraps without overflow.
    step(1, 0, 8191);
    enables_with_gaps(8191, 0, 8191);
    enables_with_gaps(1, 2, 8191);

    // clear beats count_enable at value 8.
    step(1, 0, 10);
    enables_with_gaps(8, 0, 10);
    step(1, 1, 10);
    step(0, 0, 10);

    // Degenerate widths: every enable wraps.
    step(1, 0, 2);
    enables_with_gaps(3, 1, 2);
    step(1, 0, 1);
    enables_with_gaps(3, 1, 1);
    enables_with_gaps(2, 0, 0);

    // Width lowered mid-row from 100 to 10 at value 50.
    step(1, 0, 100);
    enables_with_gaps(50, 0, 100);
    step(0, 1, 10);
    step(0, 0, 10);
    step(0, 1, 10);

    // Randomised traffic with small, changing widths.
    begin
      int rv;
      rv = 7;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 15) == 0) rv = $urandom_range(0, 12);
        step($urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0, rv);
      end
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
